stream_sink_checker: RTL and testbench
======================================

Name: stream_sink_checker

Overview:
- Receiving end of the team's valid/ready stream interface. It consumes beats from a producer or pipeline stage output and applies ready/backpressure.
- Checks each beat against an expected incrementing sequence, counts beats and mismatches, and flags handshake-protocol violations by the upstream side.
- Used as the downstream terminator in block-level benches and in on-chip stream self-test.

Parameters:
- DATA_WIDTH, 8, width of in_data and of the expected-value register
- COUNT_WIDTH, 16, width of the beat target, beat counter and error counter
- LFSR_SEED, 16'hACE1, non-zero reset seed of the 16-bit backpressure LFSR (used only with the optional feature)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse: begin a check run
- expected_start  input  DATA_WIDTH  first expected data value, sampled on start
- beat_target  input  COUNT_WIDTH  number of beats to accept, sampled on start
- in_data  input  DATA_WIDTH  stream data
- in_valid  input  1  stream valid
- in_ready  output  1  stream ready (registered)
- busy  output  1  high while in RUN
- done  output  1  high in DONE; held until the next start
- beat_cnt  output  COUNT_WIDTH  beats accepted in the current run
- err_cnt  output  COUNT_WIDTH  data mismatches; saturates at all-ones
- first_err_idx  output  COUNT_WIDTH  beat index of the first mismatch
- first_err_data  output  DATA_WIDTH  data value of the first mismatch
- proto_err  output  1  sticky handshake-violation flag

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs go to 0.
  - The expected register goes to 0 and the LFSR goes to LFSR_SEED.
- The design has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0.
  - On start, sample expected_start and beat_target, and clear beat_cnt, err_cnt, first_err_*, and proto_err.
  - If beat_target==0, go to DONE. Otherwise go to RUN.
- RUN:
  - busy=1.
  - A transfer occurs on a cycle where in_valid && in_ready.
  - On each transfer:
    - Compare in_data with the expected value.
    - On mismatch, increment err_cnt (saturating). If this is the first mismatch, capture beat_cnt into first_err_idx and in_data into first_err_data.
    - The expected value increments modulo 2^DATA_WIDTH, so 8'hFF is followed by 8'h00.
    - beat_cnt increments.
  - On the transfer where beat_cnt == beat_target-1, go to DONE. in_ready is 0 from the next cycle on, so no extra beat is accepted.
  - start is ignored in RUN.
- DONE:
  - done=1, busy=0, in_ready=0.
  - On start, behave exactly as start in IDLE (re-arm and clear).
- in_ready is a flop output and has no combinational path from in_valid or in_data.
- Without backpressure, in_ready is 1 on every RUN cycle, including the first cycle after start.
- Protocol check (in RUN only):
  - If in_valid was 1 and in_ready was 0 on the previous cycle, then on this cycle in_valid must still be 1 and in_data must be unchanged.
  - Any violation sets proto_err, which stays set until the next start or reset.
  - No beat is accepted on a violating cycle unless the beat is also a valid transfer. Counting proceeds normally.
- beat_cnt counts to beat_target and cannot wrap within a run.
- Reset mid-run aborts immediately to IDLE with all outputs cleared.
- If start and reset occur in the same cycle, reset wins.

Optional Feature:
- Macro: STREAM_SINK_BACKPRESSURE_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances on every RUN cycle.
  - in_ready for the next cycle equals LFSR bit 0 while in RUN, giving a deterministic pseudo-random stall pattern.
  - The LFSR is not reloaded on start.
- Undefined:
  - The LFSR logic is absent.
  - in_ready=1 throughout RUN.

Test Plan:
- Reset behaviour: hold reset=1 for 3 cycles with in_valid=1 -> in_ready, busy, done, beat_cnt, err_cnt and proto_err are all 0. After release with no start, the block stays in IDLE.
- Clean run: start with expected_start=8'h15 and beat_target=4, then drive 15,16,17,18 back-to-back with in_valid=1 -> beat_cnt=4, err_cnt=0, done=1 on the cycle after the 4th transfer, and in_ready=0 thereafter.
- Wrap and mismatch: start with expected_start=8'hFE and beat_target=4, then drive FE,FF,05,01 -> err_cnt=1, first_err_idx=2, first_err_data=8'h05. The expected value after FF is 00.
- Stall and protocol violation: with the macro defined, drive 8'h3C. While in_ready=0, change in_data to 8'h3D -> proto_err=1 and stays 1 through DONE. A fresh start clears it.
- Zero target and restart: start with beat_target=0 -> done=1 on the next cycle with no transfers. Then start with beat_target=2 from DONE -> done drops and busy=1.
- Mid-run reset: assert reset after 2 of 5 beats -> all outputs are 0 on the next cycle. A new start begins a clean run.

Source files
------------

// File: rtl/stream_sink_checker.sv
// Valid/ready stream sink: checks an incrementing data sequence, counts beats/mismatches,
// flags upstream handshake violations. Optional LFSR backpressure: STREAM_SINK_BACKPRESSURE_EN.
module stream_sink_checker #(
    parameter int          DATA_WIDTH  = 8,
    parameter int          COUNT_WIDTH = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  expected_start,
    input  logic [COUNT_WIDTH-1:0] beat_target,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] beat_cnt,
    output logic [COUNT_WIDTH-1:0] err_cnt,
    output logic [COUNT_WIDTH-1:0] first_err_idx,
    output logic [DATA_WIDTH-1:0]  first_err_data,
    output logic                   proto_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]             state;
    logic [DATA_WIDTH-1:0]  exp_q;
    logic [COUNT_WIDTH-1:0] tgt_q;
    logic                   stall_q;
    logic [DATA_WIDTH-1:0]  data_q;

    logic                   xfer;
    logic                   violation;
    logic [COUNT_WIDTH-1:0] cnt_inc;
    logic                   ready_start;
    logic                   ready_next;

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign xfer      = (state == RUN) && in_valid && in_ready;
    assign cnt_inc   = beat_cnt + 1'b1;
    // A beat offered but stalled last cycle must be held with identical data.
    assign violation = (state == RUN) && stall_q && (!in_valid || (in_data != data_q));

`ifdef STREAM_SINK_BACKPRESSURE_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    assign lfsr_next   = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign ready_start = lfsr[0];
    assign ready_next  = lfsr_next[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (state == RUN) begin
            lfsr <= lfsr_next;
        end
    end
`else
    assign ready_start = 1'b1;
    assign ready_next  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            in_ready       <= 1'b0;
            beat_cnt       <= '0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            proto_err      <= 1'b0;
            exp_q          <= '0;
            tgt_q          <= '0;
            stall_q        <= 1'b0;
            data_q         <= '0;
        end else begin
            stall_q <= (state == RUN) && in_valid && !in_ready;
            data_q  <= in_data;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        exp_q          <= expected_start;
                        tgt_q          <= beat_target;
                        beat_cnt       <= '0;
                        err_cnt        <= '0;
                        first_err_idx  <= '0;
                        first_err_data <= '0;
                        proto_err      <= 1'b0;
                        if (beat_target == '0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                        end else begin
                            state    <= RUN;
                            in_ready <= ready_start;
                        end
                    end
                end
                RUN: begin
                    if (violation) begin
                        proto_err <= 1'b1;
                    end
                    in_ready <= ready_next;
                    if (xfer) begin
                        // err_cnt never returns to zero within a run, so zero marks "no mismatch yet".
                        if (in_data != exp_q) begin
                            if (err_cnt == '0) begin
                                first_err_idx  <= beat_cnt;
                                first_err_data <= in_data;
                            end
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end
                        exp_q    <= exp_q + 1'b1;
                        beat_cnt <= cnt_inc;
                        if (cnt_inc == tgt_q) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_sink_checker.sv
// Directed bench for stream_sink_checker: a per-cycle reference model plus literal checkpoints.
// Define STREAM_SINK_BACKPRESSURE_EN to also exercise the stall/protocol scenario.
module tb_stream_sink_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  expected_start;
    logic [15:0] beat_target;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [15:0] beat_cnt;
    logic [15:0] err_cnt;
    logic [15:0] first_err_idx;
    logic [7:0]  first_err_data;
    logic        proto_err;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    stream_sink_checker #(
        .DATA_WIDTH (8),
        .COUNT_WIDTH(16),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .expected_start(expected_start),
        .beat_target   (beat_target),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .busy          (busy),
        .done          (done),
        .beat_cnt      (beat_cnt),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .first_err_data(first_err_data),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: run bookkeeping from the behavioural rules, one step per rising edge.
    bit          m_running, m_done, m_ready, m_proto, prev_stall;
    int          m_cnt, m_tgt, m_err, m_fidx;
    logic [7:0]  m_exp, m_fdata, prev_data;
    logic [15:0] m_lfsr;
    bit          m_bp;

    initial begin
`ifdef STREAM_SINK_BACKPRESSURE_EN
        m_bp = 1'b1;
`else
        m_bp = 1'b0;
`endif
    end

    always @(posedge clk) begin
        if (reset) begin
            m_running = 0; m_done = 0; m_ready = 0; m_proto = 0; prev_stall = 0;
            m_cnt = 0; m_tgt = 0; m_err = 0; m_fidx = 0;
            m_exp = 8'h00; m_fdata = 8'h00; prev_data = 8'h00; m_lfsr = 16'hACE1;
        end else if (m_running) begin
            if (prev_stall && (!in_valid || in_data != prev_data)) m_proto = 1;
            if (in_valid && m_ready) begin
                if (in_data != m_exp) begin
                    if (m_err == 0) begin m_fidx = m_cnt; m_fdata = in_data; end
                    if (m_err < 65535) m_err = m_err + 1;
                end
                m_exp = m_exp + 8'd1;
                m_cnt = m_cnt + 1;
            end
            prev_stall = in_valid && !m_ready;
            prev_data  = in_data;
            m_lfsr = {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
            if (m_cnt == m_tgt) begin
                m_running = 0; m_done = 1; m_ready = 0;
            end else begin
                m_ready = m_bp ? m_lfsr[0] : 1'b1;
            end
        end else begin
            prev_stall = 0;
            if (start) begin
                m_exp = expected_start; m_tgt = int'(beat_target);
                m_cnt = 0; m_err = 0; m_fidx = 0; m_fdata = 8'h00; m_proto = 0;
                if (m_tgt == 0) begin
                    m_done = 1; m_ready = 0;
                end else begin
                    m_running = 1; m_done = 0; m_ready = m_bp ? m_lfsr[0] : 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",       32'(in_ready),       32'(m_ready));
            chk("busy",           32'(busy),           32'(m_running));
            chk("done",           32'(done),           32'(m_done));
            chk("beat_cnt",       32'(beat_cnt),       32'(m_cnt));
            chk("err_cnt",        32'(err_cnt),        32'(m_err));
            chk("first_err_idx",  32'(first_err_idx),  32'(m_fidx));
            chk("first_err_data", 32'(first_err_data), 32'(m_fdata));
            chk("proto_err",      32'(proto_err),      32'(m_proto));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] es, input logic [15:0] tgt);
        start = 1'b1; expected_start = es; beat_target = tgt;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1; in_data = d;
        for (int k = 0; k < 64 && !ok; k++) begin
            ok = in_ready;
            tick();
        end
        if (!ok) begin
            n_total++;
            $display("FAIL send_timeout: got no ready expected ready for data %0h", d);
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_run();
        for (int k = 0; k < 400 && !done; k++) begin
            if (in_ready) in_data = in_data + 8'd1;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("finish_done", 32'(done), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; expected_start = 8'h00; beat_target = 16'd0;
        in_data = 8'h00; in_valid = 1'b1;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_err_cnt",  32'(err_cnt),  32'd0);
        chk("rst_proto",    32'(proto_err), 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        repeat (3) tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // Clean run
        do_start(8'h15, 16'd4);
        send(8'h15); send(8'h16); send(8'h17); send(8'h18);
        chk("clean_done",     32'(done),     32'd1);
        chk("clean_beat_cnt", 32'(beat_cnt), 32'd4);
        chk("clean_err_cnt",  32'(err_cnt),  32'd0);
        chk("clean_ready",    32'(in_ready), 32'd0);
        tick();
        chk("clean_ready2",   32'(in_ready), 32'd0);

        // Wrap and mismatch
        do_start(8'hFE, 16'd4);
        send(8'hFE); send(8'hFF); send(8'h05); send(8'h01);
        chk("wrap_err_cnt", 32'(err_cnt),        32'd1);
        chk("wrap_idx",     32'(first_err_idx),  32'd2);
        chk("wrap_data",    32'(first_err_data), 32'h05);
        chk("wrap_done",    32'(done),           32'd1);

`ifdef STREAM_SINK_BACKPRESSURE_EN
        // Stall then change data while stalled
        do_start(8'h3C, 16'd20);
        in_valid = 1'b1; in_data = 8'h3C;
        for (int k = 0; k < 60; k++) begin
            if (!in_ready && busy) begin
                tick();
                in_data = in_data + 8'd1;
                tick();
                break;
            end
            if (in_ready) in_data = in_data + 8'd1;
            tick();
        end
        chk("stall_proto", 32'(proto_err), 32'd1);
        finish_run();
        chk("stall_proto_done", 32'(proto_err), 32'd1);
        do_start(8'h00, 16'd1);
        chk("stall_proto_clr", 32'(proto_err), 32'd0);
        finish_run();
`endif

        // Zero target, then restart from DONE
        do_start(8'h77, 16'd0);
        chk("zero_done",     32'(done),     32'd1);
        chk("zero_busy",     32'(busy),     32'd0);
        chk("zero_beat_cnt", 32'(beat_cnt), 32'd0);
        do_start(8'h00, 16'd2);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        send(8'h00); send(8'h01);
        chk("restart_fin", 32'(done), 32'd1);

        // Mid-run reset
        do_start(8'h40, 16'd5);
        send(8'h40); send(8'h41);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_busy",     32'(busy),     32'd0);
        chk("mrst_done",     32'(done),     32'd0);
        chk("mrst_ready",    32'(in_ready), 32'd0);
        chk("mrst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("mrst_err_cnt",  32'(err_cnt),  32'd0);
        do_start(8'h50, 16'd2);
        send(8'h50); send(8'h51);
        chk("post_done",     32'(done),     32'd1);
        chk("post_beat_cnt", 32'(beat_cnt), 32'd2);
        chk("post_err_cnt",  32'(err_cnt),  32'd0);

        repeat (2) tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
